dmem_responder: RTL
===================

# dmem_responder

Memory-side responder for the data-cache memory port: it answers `mem_rdreq`/`mem_wrreq` from the dcache with single-word writes and fixed-latency read bursts. It is backed by an on-chip word array. It replaces the behavioural RAM used in cache benches and serves as the simulation and FPGA backing store behind `dcache`. All port names match the dcache memory port, so the two connect one-to-one.

## Interface
- `DATABITS`, 32, word width.
- `ADDRBITS`, 32, byte-address width of `mem_addr`.
- `MEMADDRBITS`, 9, log2 of array depth in words (512 words).
- `READ_LATENCY`, 2, cycles from request to first data; legal range 1..15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `mem_addr`  in  ADDRBITS  byte address; bits [1:0] ignored.
- `mem_in`  in  DATABITS  write data.
- `mem_out`  out  DATABITS  read data.
- `mem_out_valid`  out  1  `mem_out` holds a burst word this cycle.
- `mem_rdreq`  in  1  read request; one-cycle pulse.
- `mem_wrreq`  in  1  write strobe; one word per high cycle.
- `mem_burstlen`  in  16  read burst length in words; 0 treated as 1.
- `mem_err`  out  1  sticky protocol-violation flag.

## Operation
- Word index is `mem_addr[MEMADDRBITS+1:2]`. Upper address bits are ignored, so the array aliases.
- FSM states:
  - IDLE
    - `mem_wrreq` writes `mem_in` at the word index; stay in IDLE.
    - `mem_rdreq` latches the word index and burst length (0→1), loads the latency counter, and goes to WAIT.
  - WAIT
    - Count down READ_LATENCY-1 cycles, then go to BURST.
    - With READ_LATENCY=1, WAIT is skipped.
  - BURST
    - Emit one word per cycle with `mem_out_valid`=1.
    - Increment the word index modulo 2^MEMADDRBITS and decrement the remaining count.
    - After the last word, go to IDLE.
- Write during WAIT/BURST: the write is dropped and `mem_err` is set.
- Read during WAIT/BURST: the read is dropped and `mem_err` is set.
- `mem_rdreq` and `mem_wrreq` together in IDLE: the write is performed, the read is dropped, and `mem_err` is set.
- A new `mem_rdreq` is legal in the cycle after the last valid word.
- `mem_err` clears only on reset.
- Array contents are not reset.

## Timing
- Reset values: `mem_out`=0, `mem_out_valid`=0, `mem_err`=0, FSM=IDLE, counters=0.
- `mem_rdreq` high in cycle c gives the first `mem_out_valid` in cycle c+READ_LATENCY. Word k arrives in cycle c+READ_LATENCY+k.
- Valid words are contiguous with no gaps. `mem_out` is registered.
- A write in IDLE at cycle c is visible to a read issued in cycle c+1 or later. There is no read-during-write forwarding within the same cycle.
- Outside BURST, `mem_out_valid`=0 and `mem_out` holds its last value.
- Reset asserted mid-burst:
  - `mem_out_valid` drops immediately (async) and no further words are emitted.
  - After release, the FSM is in IDLE.
- `mem_burstlen`=65535 is legal. The remaining-words counter is 16 bits and counts down to 0 without underflow.

## Structure
- Package `dmem_pkg`:
  - FSM state enum (IDLE/WAIT/BURST).
  - `word_index` width helper.
  - Burst-count width constant (16).
- Sub-module `dmem_sram`: a single-port word array with synchronous write and synchronous (registered) read, parameterised by DATABITS/MEMADDRBITS.
- The top level contains the FSM, the address/count registers and the error logic.

## Test plan
- Write `0fff0001..0fff0008` to `0x80..0x9c` (one per cycle), then rdreq at `0x80` with burstlen 8 → eight valid words `0fff0001..0fff0008` in consecutive cycles starting READ_LATENCY after the request; `mem_err`=0.
- READ_LATENCY=1, rdreq at `0x84` with burstlen 1 → exactly one valid cycle, data `0fff0002`, in the cycle after the request.
- Burstlen 0 at `0x88` → one word `0fff0003`; `mem_err`=0.
- Wrap: write `A5A5A5A5` at `0x7fc` (word 511), rdreq at `0x7fc` with burstlen 2 → `A5A5A5A5`, then word 0's contents.
- Protocol violations:
  - wrreq with `DEADBEEF` at `0x80` during a BURST → `mem_err`=1, the burst completes unchanged, and a later read of `0x80` returns the old value.
  - rdreq during WAIT → ignored and `mem_err`=1.
- Reset mid-burst of 8 after the third word → `mem_out_valid`=0 immediately and `mem_err`=0. A new rdreq afterwards returns the correct data.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the dcache memory-side responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_BURST
  } state_e;

  localparam int unsigned BURST_BITS = 16;
  localparam int unsigned LAT_BITS   = 4;

  // Highest byte-address bit that still selects a word in the array.
  function automatic int unsigned word_index_msb(input int unsigned memaddrbits);
    return memaddrbits + 1;
  endfunction

endpackage

// File: rtl/dmem_sram.sv
// Single-port word array: synchronous write, registered read output.
module dmem_sram #(
  parameter int unsigned DATABITS    = 32,
  parameter int unsigned MEMADDRBITS = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic                   re,
  input  logic [MEMADDRBITS-1:0] addr,
  input  logic [DATABITS-1:0]    wdata,
  output logic [DATABITS-1:0]    rdata
);

  localparam int unsigned DEPTH = 1 << MEMADDRBITS;

  logic [DATABITS-1:0] mem_q [DEPTH];
  logic [DATABITS-1:0] rdata_q;
  logic [DATABITS-1:0] rdata_d;

  // Array contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the dcache port: single-word writes and
// fixed-latency read bursts from an on-chip word array.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DATABITS     = 32,
  parameter int unsigned ADDRBITS     = 32,
  parameter int unsigned MEMADDRBITS  = 9,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDRBITS-1:0] mem_addr,
  input  logic [DATABITS-1:0] mem_in,
  output logic [DATABITS-1:0] mem_out,
  output logic                mem_out_valid,
  input  logic                mem_rdreq,
  input  logic                mem_wrreq,
  input  logic [15:0]         mem_burstlen,
  output logic                mem_err
);

  localparam int unsigned IDX_MSB  = word_index_msb(MEMADDRBITS);
  localparam int unsigned LAT_LOAD = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;
  localparam logic [BURST_BITS-1:0]  ONE_CNT = 1;
  localparam logic [MEMADDRBITS-1:0] ONE_IDX = 1;
  localparam logic [LAT_BITS-1:0]    ONE_LAT = 1;

  state_e                  state_q, state_d;
  logic [MEMADDRBITS-1:0]  idx_q, idx_d;
  logic [BURST_BITS-1:0]   cnt_q, cnt_d;
  logic [LAT_BITS-1:0]     lat_q, lat_d;
  logic                    valid_q, valid_d;
  logic                    err_q, err_d;

  logic                    busy;
  logic [MEMADDRBITS-1:0]  req_idx;
  logic [BURST_BITS-1:0]   req_len;
  logic                    issue;
  logic [MEMADDRBITS-1:0]  issue_idx;
  logic [BURST_BITS-1:0]   issue_cnt;
  logic                    sram_we;
  logic                    sram_re;
  logic [MEMADDRBITS-1:0]  sram_addr;
  logic                    addr_unused;

  assign addr_unused = ^{mem_addr[ADDRBITS-1:IDX_MSB+1], mem_addr[1:0]};
  assign req_idx     = mem_addr[IDX_MSB:2];
  assign req_len     = (mem_burstlen == '0) ? ONE_CNT : mem_burstlen;
  // The SRAM read is issued one edge ahead of each valid word, so the cycle
  // showing the final word is still busy even though the FSM is back in IDLE.
  assign busy        = (state_q != ST_IDLE) || valid_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    lat_d     = lat_q;
    valid_d   = 1'b0;
    err_d     = err_q;
    issue     = 1'b0;
    issue_idx = idx_q;
    issue_cnt = cnt_q;
    sram_we   = 1'b0;
    sram_re   = 1'b0;
    sram_addr = idx_q;

    if (busy && (mem_rdreq || mem_wrreq)) begin
      err_d = 1'b1;
    end
    if (!busy && mem_rdreq && mem_wrreq) begin
      err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (!busy) begin
          if (mem_wrreq) begin
            sram_we   = 1'b1;
            sram_addr = req_idx;
          end else if (mem_rdreq) begin
            if (READ_LATENCY <= 1) begin
              issue     = 1'b1;
              issue_idx = req_idx;
              issue_cnt = req_len;
            end else begin
              idx_d   = req_idx;
              cnt_d   = req_len;
              lat_d   = LAT_BITS'(LAT_LOAD);
              state_d = ST_WAIT;
            end
          end
        end
      end
      ST_WAIT: begin
        if (lat_q == '0) begin
          issue = 1'b1;
        end else begin
          lat_d = lat_q - ONE_LAT;
        end
      end
      ST_BURST: begin
        issue = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (issue) begin
      sram_re   = 1'b1;
      sram_addr = issue_idx;
      valid_d   = 1'b1;
      idx_d     = issue_idx + ONE_IDX;
      cnt_d     = issue_cnt - ONE_CNT;
      state_d   = (issue_cnt == ONE_CNT) ? ST_IDLE : ST_BURST;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      lat_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  dmem_sram #(
    .DATABITS    (DATABITS),
    .MEMADDRBITS (MEMADDRBITS)
  ) u_sram (
    .clk   (clk),
    .rst   (reset),
    .we    (sram_we),
    .re    (sram_re),
    .addr  (sram_addr),
    .wdata (mem_in),
    .rdata (mem_out)
  );

  assign mem_out_valid = valid_q;
  assign mem_err       = err_q;

endmodule
